// File: rtl/axi4_master_cmd_arbiter.sv
// axi4_master_cmd_arbiter: round-robin front end sharing one axi4_master
// command port between NUM_REQ clients, with a transaction watchdog.
module axi4_master_cmd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_areset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [24*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0]  req_len,
  input  logic [32*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_accept,
  output logic [NUM_REQ-1:0]    req_done,
  output logic                  req_err,
  output logic [31:0]           rsp_rdata,
  output logic [IDW-1:0]        grant_id,
  input  logic                  mst_idle,
  input  logic                  mst_done,
  input  logic [31:0]           mst_rdata,
  output logic                  mst_write,
  output logic                  mst_read,
  output logic [23:0]           mst_addr,
  output logic [7:0]            mst_len,
  output logic [31:0]           mst_wdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [15:0]    TO_VAL   = 16'(TIMEOUT);
  localparam logic [IDW-1:0] PTR_INIT = IDW'(NUM_REQ - 1);

  state_t               state_q, state_d;
  logic [15:0]          timer_q, timer_d;
  logic [15:0]          timer_inc;
  logic                 wdog;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic                 cmd_wr_q, cmd_wr_d;
  logic [IDW-1:0]       gid_d;
  logic [23:0]          addr_d;
  logic [7:0]           len_d;
  logic [31:0]          wdata_d;
  logic [31:0]          rdata_d;
  logic [NUM_REQ-1:0]   accept_d;
  logic [NUM_REQ-1:0]   done_d;
  logic                 err_d;
  logic                 mwr_d;
  logic                 mrd_d;
  logic                 arb_any;
  logic [IDW-1:0]       arb_gnt;
  logic [IDW-1:0]       arb_sel;

  assign timer_inc = timer_q + 16'd1;
  assign wdog      = (timer_inc == TO_VAL);

  // Round-robin pick: nearest valid requester after ptr, wrapping.
  always_comb begin
    arb_any = 1'b0;
    arb_gnt = '0;
    arb_sel = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      arb_sel = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid[arb_sel]) begin
        arb_any = 1'b1;
        arb_gnt = arb_sel;
      end
    end
  end

  // Next-state and next-output logic; mst_done beats the watchdog.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    ptr_d    = ptr_q;
    cmd_wr_d = cmd_wr_q;
    gid_d    = grant_id;
    addr_d   = mst_addr;
    len_d    = mst_len;
    wdata_d  = mst_wdata;
    rdata_d  = rsp_rdata;
    accept_d = '0;
    done_d   = '0;
    err_d    = 1'b0;
    mwr_d    = 1'b0;
    mrd_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          gid_d             = arb_gnt;
          cmd_wr_d          = req_write[arb_gnt];
          addr_d            = req_addr[arb_gnt*24 +: 24];
          len_d             = req_len[arb_gnt*8 +: 8];
          wdata_d           = req_wdata[arb_gnt*32 +: 32];
          accept_d[arb_gnt] = 1'b1;
          timer_d           = '0;
          state_d           = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = timer_inc;
        if (wdog) begin
          done_d[grant_id] = 1'b1;
          err_d            = 1'b1;
          state_d          = S_RESP;
        end else if (mst_idle) begin
          mwr_d   = cmd_wr_q;
          mrd_d   = !cmd_wr_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_inc;
        if (mst_done) begin
          if (!cmd_wr_q) begin
            rdata_d = mst_rdata;
          end
          done_d[grant_id] = 1'b1;
          state_d          = S_RESP;
        end else if (wdog) begin
          done_d[grant_id] = 1'b1;
          err_d            = 1'b1;
          state_d          = S_RESP;
        end
      end
      S_RESP: begin
        ptr_d   = grant_id;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts silently.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      ptr_q      <= PTR_INIT;
      cmd_wr_q   <= 1'b0;
      grant_id   <= '0;
      mst_addr   <= '0;
      mst_len    <= '0;
      mst_wdata  <= '0;
      rsp_rdata  <= '0;
      req_accept <= '0;
      req_done   <= '0;
      req_err    <= 1'b0;
      mst_write  <= 1'b0;
      mst_read   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ptr_q      <= ptr_d;
      cmd_wr_q   <= cmd_wr_d;
      grant_id   <= gid_d;
      mst_addr   <= addr_d;
      mst_len    <= len_d;
      mst_wdata  <= wdata_d;
      rsp_rdata  <= rdata_d;
      req_accept <= accept_d;
      req_done   <= done_d;
      req_err    <= err_d;
      mst_write  <= mwr_d;
      mst_read   <= mrd_d;
    end
  end

endmodule

// File: tb/tb_axi4_master_cmd_arbiter.sv
// tb_axi4_master_cmd_arbiter: scoreboard bench for the command arbiter
// with a simple axi4_master responder model.
module tb_axi4_master_cmd_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [24*N-1:0] req_addr;
  logic [8*N-1:0]  req_len;
  logic [32*N-1:0] req_wdata;
  logic [N-1:0]    req_accept;
  logic [N-1:0]    req_done;
  logic            req_err;
  logic [31:0]     rsp_rdata;
  logic [IDW-1:0]  grant_id;
  logic            mst_idle;
  logic            mst_done;
  logic [31:0]     mst_rdata;
  logic            mst_write;
  logic            mst_read;
  logic [23:0]     mst_addr;
  logic [7:0]      mst_len;
  logic [31:0]     mst_wdata;

  axi4_master_cmd_arbiter #(
    .NUM_REQ(N),
    .IDW    (IDW),
    .TIMEOUT(TO)
  ) dut (
    .m_axi_aclk  (clk),
    .m_axi_areset(rst),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_wdata   (req_wdata),
    .req_accept  (req_accept),
    .req_done    (req_done),
    .req_err     (req_err),
    .rsp_rdata   (rsp_rdata),
    .grant_id    (grant_id),
    .mst_idle    (mst_idle),
    .mst_done    (mst_done),
    .mst_rdata   (mst_rdata),
    .mst_write   (mst_write),
    .mst_read    (mst_read),
    .mst_addr    (mst_addr),
    .mst_len     (mst_len),
    .mst_wdata   (mst_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [23:0] a;
    logic [7:0]  l;
    logic [31:0] d;
  } cmd_t;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rd;
  } rsp_t;

  int   exp_gnt[$];
  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        r_write[N];
  logic [23:0] r_addr[N];
  logic [7:0]  r_len[N];
  logic [31:0] r_wdata[N];

  logic        hold    = 1'b0;
  logic        m_never = 1'b0;
  logic        exp_err = 1'b0;
  int          m_delay = 1;
  int          mcnt    = 0;
  logic [31:0] m_rdata = '0;
  logic [31:0] last_rd = '0;
  int          acc_cyc = 0;
  int          pls_cyc = 0;
  int          done_cyc = 0;
  int          acc_n = 0;
  int          pls_n = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // One clock step; requesters drop on accept, master answers pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!hold) req_valid = req_valid & ~req_accept;
    mst_done = 1'b0;
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        mst_done  = 1'b1;
        mst_rdata = m_rdata;
      end
    end
    if ((mst_write || mst_read) && !m_never) mcnt = m_delay;
  endtask

  task automatic set_req(input int i, input logic w, input logic [23:0] a,
                         input logic [7:0] l, input logic [31:0] d);
    r_write[i] = w;
    r_addr[i]  = a;
    r_len[i]   = l;
    r_wdata[i] = d;
    req_write[i]           = w;
    req_addr[i*24 +: 24]   = a;
    req_len[i*8 +: 8]      = l;
    req_wdata[i*32 +: 32]  = d;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget &&
           (exp_gnt.size() + exp_cmd.size() + exp_rsp.size()) != 0) begin
      tick();
      n++;
    end
    check({"drain_", tag},
          exp_gnt.size() + exp_cmd.size() + exp_rsp.size(), 0);
    tick();
  endtask

  // Scoreboard: grants push expected commands/responses, outputs pop them.
  always @(negedge clk) begin : mon
    int           g;
    cmd_t         c;
    rsp_t         r;
    logic [N-1:0] oh;
    if (!rst) begin
      if (req_accept != '0) begin
        acc_cyc = cyc;
        acc_n++;
        if (exp_gnt.size() == 0) begin
          check("spur_accept", req_accept, 0);
        end else begin
          g = exp_gnt.pop_front();
          oh = '0;
          oh[g] = 1'b1;
          check("grant_id", grant_id, g);
          check("accept_vec", req_accept, oh);
          c.w = r_write[g];
          c.a = r_addr[g];
          c.l = r_len[g];
          c.d = r_wdata[g];
          exp_cmd.push_back(c);
          if (!exp_err && !r_write[g]) last_rd = m_rdata;
          r.id  = g;
          r.err = exp_err;
          r.rd  = last_rd;
          exp_rsp.push_back(r);
        end
      end
      if (mst_write || mst_read) begin
        pls_cyc = cyc;
        pls_n++;
        if (exp_cmd.size() == 0) begin
          check("spur_cmd", {mst_write, mst_read}, 0);
        end else begin
          c = exp_cmd.pop_front();
          check("cmd_write", mst_write, c.w);
          check("cmd_read", mst_read, !c.w);
          check("cmd_addr", mst_addr, c.a);
          check("cmd_len", mst_len, c.l);
          check("cmd_wdata", mst_wdata, c.d);
        end
      end
      if (req_done != '0) begin
        done_cyc = cyc;
        if (exp_rsp.size() == 0) begin
          check("spur_done", req_done, 0);
        end else begin
          r = exp_rsp.pop_front();
          oh = '0;
          oh[r.id] = 1'b1;
          check("done_vec", req_done, oh);
          check("done_err", req_err, r.err);
          check("done_rdata", rsp_rdata, r.rd);
        end
      end else if (req_err) begin
        check("err_no_done", req_err, 0);
      end
    end
  end

  initial begin
    int a0;
    int p0;
    int t0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_len   = '0;
    req_wdata = '0;
    mst_idle  = 1'b1;
    mst_done  = 1'b0;
    mst_rdata = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, '0);
    rst = 1'b1;
    repeat (3) tick();
    check("rst_ctl", {req_accept, req_done, req_err, grant_id,
                      mst_write, mst_read, mst_len}, 0);
    check("rst_data", {rsp_rdata, mst_wdata}, 0);
    check("rst_addr", mst_addr, 0);
    rst = 1'b0;
    tick();

    // all four held: fair rotation 0,1,2,3,0
    for (int i = 0; i < N; i++)
      set_req(i, (i % 2) == 0, 24'(32'h1000 * i + 4), 8'(i),
              32'h11111111 * i);
    m_delay = 3;
    m_rdata = 32'h12345678;
    exp_err = 1'b0;
    hold    = 1'b1;
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    exp_gnt.push_back(2);
    exp_gnt.push_back(3);
    exp_gnt.push_back(0);
    req_valid = '1;
    for (int i = 0; i < 300 && exp_gnt.size() != 0; i++) tick();
    req_valid = '0;
    hold = 1'b0;
    drain("rr", 100);

    // single write from requester 1, latency checks
    set_req(1, 1'b1, 24'h000100, 8'd3, 32'hA5A50000);
    m_delay = 6;
    exp_gnt.push_back(1);
    t0 = cyc;
    req_valid[1] = 1'b1;
    drain("wr1", 100);
    check("wr1_acc_lat", acc_cyc - t0, 1);
    check("wr1_cmd_lat", pls_cyc - acc_cyc, 1);
    check("wr1_done_lat", done_cyc - pls_cyc, 7);

    // read from requester 2
    set_req(2, 1'b0, 24'h00ABC0, 8'd0, 32'h0);
    m_rdata = 32'hDEADBEEF;
    m_delay = 4;
    exp_gnt.push_back(2);
    req_valid[2] = 1'b1;
    drain("rd2", 100);
    check("rd2_rdata", rsp_rdata, 32'hDEADBEEF);

    // watchdog: master never finishes, both pending requests abort
    set_req(0, 1'b0, 24'h000040, 8'd1, 32'h0);
    set_req(3, 1'b1, 24'h000080, 8'd2, 32'hCAFE0003);
    m_never = 1'b1;
    exp_err = 1'b1;
    exp_gnt.push_back(3);
    exp_gnt.push_back(0);
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    drain("wdog", 100);
    check("wdog_lat", done_cyc - acc_cyc, TO);
    check("wdog_rdata", rsp_rdata, 32'hDEADBEEF);
    m_never = 1'b0;
    mcnt    = 0;

    // master busy 5 cycles, mst_done on the watchdog cycle
    exp_err  = 1'b0;
    mst_idle = 1'b0;
    set_req(1, 1'b1, 24'hFFFFFC, 8'hFF, 32'hFFFFFFFF);
    m_delay = 1;
    exp_gnt.push_back(1);
    a0 = acc_n;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 50 && acc_n == a0; i++) tick();
    check("busy_acc", acc_n - a0, 1);
    repeat (4) tick();
    mst_idle = 1'b1;
    drain("busy", 100);
    check("busy_cmd_lat", pls_cyc - acc_cyc, 6);
    check("busy_done_lat", done_cyc - acc_cyc, TO);

    // same but mst_done one cycle too late: watchdog wins
    exp_err  = 1'b1;
    mst_idle = 1'b0;
    set_req(2, 1'b0, 24'h000200, 8'd7, 32'h0);
    m_rdata = 32'h0BADF00D;
    m_delay = 2;
    exp_gnt.push_back(2);
    a0 = acc_n;
    req_valid[2] = 1'b1;
    for (int i = 0; i < 50 && acc_n == a0; i++) tick();
    repeat (4) tick();
    mst_idle = 1'b1;
    drain("late", 100);
    check("late_done_lat", done_cyc - acc_cyc, TO);
    check("late_rdata", rsp_rdata, 32'hDEADBEEF);
    repeat (3) tick();

    // async reset while waiting on the master
    exp_err = 1'b0;
    set_req(1, 1'b0, 24'h000300, 8'd4, 32'h0);
    m_delay = 20;
    exp_gnt.push_back(1);
    p0 = pls_n;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 50 && pls_n == p0; i++) tick();
    check("rst_pulse_seen", pls_n - p0, 1);
    tick();
    rst = 1'b1;
    #1;
    check("arst_ctl", {req_accept, req_done, req_err, grant_id,
                       mst_write, mst_read, mst_len}, 0);
    check("arst_data", {rsp_rdata, mst_wdata}, 0);
    check("arst_addr", mst_addr, 0);
    exp_gnt.delete();
    exp_cmd.delete();
    exp_rsp.delete();
    last_rd   = '0;
    mcnt      = 0;
    req_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    set_req(0, 1'b1, 24'h000500, 8'd0, 32'h55AA55AA);
    set_req(3, 1'b0, 24'h000600, 8'd1, 32'h0);
    m_delay = 2;
    m_rdata = 32'h600DCAFE;
    exp_gnt.push_back(0);
    exp_gnt.push_back(3);
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    drain("post_rst", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
